// File: rtl/processor_controller.sv
`default_nettype none
// ============================================================================
// Module      : processor_controller
// Description : Control unit of the 16-bit programmable processor. Holds the
//               program counter and instruction register, fetches words from
//               the instruction ROM, decodes them and sequences the datapath
//               (data memory, register file, ALU) with a Moore state machine.
// Ports       : Clk        - system clock, rising edge
//               Reset      - asynchronous active-low reset
//               ROM_Data   - ROM word at address PC_Out (combinational)
//               PC_Out     - program counter / ROM address
//               IR_Out     - instruction register
//               State      - current state code
//               NextState  - state taken at the next edge
//               D_Addr     - data memory address
//               D_Wr       - data memory write enable
//               RF_s       - register-file write mux (1 = memory, 0 = ALU)
//               RF_W_Addr  - register-file write address
//               RF_W_en    - register-file write enable
//               RF_Ra_Addr - register-file read port A address
//               RF_Rb_Addr - register-file read port B address
//               ALU_s0     - ALU function (000 zero, 001 add, 010 sub)
// Revision    : 1.0 - initial release
// ============================================================================
module processor_controller (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] ROM_Data,
    output logic [6:0]  PC_Out,
    output logic [15:0] IR_Out,
    output logic [3:0]  State,
    output logic [3:0]  NextState,
    output logic [7:0]  D_Addr,
    output logic        D_Wr,
    output logic        RF_s,
    output logic [3:0]  RF_W_Addr,
    output logic        RF_W_en,
    output logic [3:0]  RF_Ra_Addr,
    output logic [3:0]  RF_Rb_Addr,
    output logic [2:0]  ALU_s0
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOADA  = 4'd4,
        S_LOADB  = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [3:0] c_OP_STORE = 4'd1;
    localparam logic [3:0] c_OP_LOAD  = 4'd2;
    localparam logic [3:0] c_OP_ADD   = 4'd3;
    localparam logic [3:0] c_OP_SUB   = 4'd4;
    localparam logic [3:0] c_OP_HALT  = 4'd5;

    localparam logic [2:0] c_ALU_ADD  = 3'b001;
    localparam logic [2:0] c_ALU_SUB  = 3'b010;

    state_t      r_state;
    state_t      w_next;
    logic [6:0]  r_pc;
    logic [15:0] r_ir;

    // State, PC and IR registers. PC/IR only move on the edge leaving Fetch.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_INIT;
            r_pc    <= 7'd0;
            r_ir    <= 16'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH) begin
                r_ir <= ROM_Data;
                r_pc <= r_pc + 7'd1;    // wraps 127 -> 0 naturally
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next = S_INIT;
        case (r_state)
            S_INIT:   w_next = S_FETCH;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (r_ir[15:12])
                    c_OP_STORE: w_next = S_STORE;
                    c_OP_LOAD:  w_next = S_LOADA;
                    c_OP_ADD:   w_next = S_ADD;
                    c_OP_SUB:   w_next = S_SUB;
                    c_OP_HALT:  w_next = S_HALT;
                    default:    w_next = S_NOOP;   // 0 and 6..15
                endcase
            end
            S_NOOP:   w_next = S_FETCH;
            S_LOADA:  w_next = S_LOADB;
            S_LOADB:  w_next = S_FETCH;
            S_STORE:  w_next = S_FETCH;
            S_ADD:    w_next = S_FETCH;
            S_SUB:    w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_INIT;   // illegal codes recover to Init
        endcase
    end

    // Moore outputs. Being decoded from the asynchronously reset state
    // register, write strobes drop the instant Reset asserts.
    always_comb begin
        D_Addr     = 8'd0;
        D_Wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_Addr  = 4'd0;
        RF_W_en    = 1'b0;
        RF_Ra_Addr = 4'd0;
        RF_Rb_Addr = 4'd0;
        ALU_s0     = 3'b000;
        case (r_state)
            S_LOADA: begin
                // Address presented one cycle ahead so the memory read settles
                D_Addr    = r_ir[11:4];
                RF_s      = 1'b1;
                RF_W_Addr = r_ir[3:0];
            end
            S_LOADB: begin
                D_Addr    = r_ir[11:4];
                RF_s      = 1'b1;
                RF_W_Addr = r_ir[3:0];
                RF_W_en   = 1'b1;
            end
            S_STORE: begin
                D_Addr     = r_ir[7:0];
                RF_Ra_Addr = r_ir[11:8];
                D_Wr       = 1'b1;
            end
            S_ADD, S_SUB: begin
                RF_Ra_Addr = r_ir[11:8];
                RF_Rb_Addr = r_ir[7:4];
                RF_W_Addr  = r_ir[3:0];
                RF_W_en    = 1'b1;
                ALU_s0     = (r_state == S_ADD) ? c_ALU_ADD : c_ALU_SUB;
            end
            default: ;
        endcase
    end

    assign State     = r_state;
    assign NextState = w_next;
    assign PC_Out    = r_pc;
    assign IR_Out    = r_ir;

endmodule
`default_nettype wire

// File: tb/tb_processor_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_processor_controller
// Description : Self-checking bench for processor_controller. An
//               instruction-level model expands each ROM word into the cycle
//               records it must produce; the DUT is compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_processor_controller;

    logic        Clk;
    logic        Reset;
    logic [15:0] ROM_Data;
    logic [6:0]  PC_Out;
    logic [15:0] IR_Out;
    logic [3:0]  State;
    logic [3:0]  NextState;
    logic [7:0]  D_Addr;
    logic        D_Wr;
    logic        RF_s;
    logic [3:0]  RF_W_Addr;
    logic        RF_W_en;
    logic [3:0]  RF_Ra_Addr;
    logic [3:0]  RF_Rb_Addr;
    logic [2:0]  ALU_s0;

    logic [15:0] rom [128];
    int          n_checks;
    int          n_fails;

    typedef struct packed {
        logic [3:0]  st;
        logic [3:0]  nx;
        logic [6:0]  pc;
        logic [15:0] ir;
        logic [7:0]  da;
        logic        dw;
        logic        rs;
        logic [3:0]  wa;
        logic        we;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [2:0]  alu;
    } rec_t;

    rec_t exp_q [$];

    processor_controller dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .ROM_Data   (ROM_Data),
        .PC_Out     (PC_Out),
        .IR_Out     (IR_Out),
        .State      (State),
        .NextState  (NextState),
        .D_Addr     (D_Addr),
        .D_Wr       (D_Wr),
        .RF_s       (RF_s),
        .RF_W_Addr  (RF_W_Addr),
        .RF_W_en    (RF_W_en),
        .RF_Ra_Addr (RF_Ra_Addr),
        .RF_Rb_Addr (RF_Rb_Addr),
        .ALU_s0     (ALU_s0)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    assign ROM_Data = rom[PC_Out];

    function automatic rec_t observed();
        rec_t r;
        r = '{st: State, nx: NextState, pc: PC_Out, ir: IR_Out, da: D_Addr,
              dw: D_Wr, rs: RF_s, wa: RF_W_Addr, we: RF_W_en,
              ra: RF_Ra_Addr, rb: RF_Rb_Addr, alu: ALU_s0};
        return r;
    endfunction

    // Expected datapath controls for a phase of an instruction
    function automatic rec_t phase(input logic [3:0] st, input logic [6:0] pc,
                                   input logic [15:0] ir);
        rec_t r;
        r    = '0;
        r.st = st;
        r.pc = pc;
        r.ir = ir;
        if (st == 4'd4 || st == 4'd5) begin          // load: addr, then write
            r.da = ir[11:4];
            r.rs = 1'b1;
            r.wa = ir[3:0];
            r.we = (st == 4'd5);
        end else if (st == 4'd6) begin               // store
            r.da = ir[7:0];
            r.ra = ir[11:8];
            r.dw = 1'b1;
        end else if (st == 4'd7 || st == 4'd8) begin // add / sub
            r.ra  = ir[11:8];
            r.rb  = ir[7:4];
            r.wa  = ir[3:0];
            r.we  = 1'b1;
            r.alu = (st == 4'd7) ? 3'b001 : 3'b010;
        end
        return r;
    endfunction

    // Expand the ROM program, instruction by instruction, into n cycle records
    task automatic build_model(input int n);
        logic [6:0]  pc;
        logic [15:0] ir;
        logic [3:0]  op;
        exp_q.delete();
        pc = '0;
        ir = '0;
        exp_q.push_back(phase(4'd0, pc, ir));
        while (exp_q.size() < n + 1) begin
            exp_q.push_back(phase(4'd1, pc, ir));
            ir = rom[pc];
            pc = pc + 7'd1;
            op = ir[15:12];
            exp_q.push_back(phase(4'd2, pc, ir));
            case (op)
                4'd1: exp_q.push_back(phase(4'd6, pc, ir));
                4'd2: begin
                    exp_q.push_back(phase(4'd4, pc, ir));
                    exp_q.push_back(phase(4'd5, pc, ir));
                end
                4'd3: exp_q.push_back(phase(4'd7, pc, ir));
                4'd4: exp_q.push_back(phase(4'd8, pc, ir));
                4'd5: while (exp_q.size() < n + 1) exp_q.push_back(phase(4'd9, pc, ir));
                default: exp_q.push_back(phase(4'd3, pc, ir));
            endcase
        end
        for (int i = 0; i < exp_q.size() - 1; i++) exp_q[i].nx = exp_q[i+1].st;
    endtask

    // Reset for 2 cycles, release, then compare n cycles against the model
    task automatic run_trace(input string name, input int n);
        rec_t o;
        build_model(n);
        Reset = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            o = observed();
            n_checks++;
            if (o !== exp_q[i]) begin
                n_fails++;
                $display("FAIL %s cycle %0d: got %h want %h (st %0d/%0d pc %h/%h ir %h/%h)",
                         name, i, o, exp_q[i], o.st, exp_q[i].st, o.pc, exp_q[i].pc,
                         o.ir, exp_q[i].ir);
            end
            @(negedge Clk);
        end
    endtask

    task automatic fill_noop();
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    endtask

    task automatic test_reset();
        rec_t o;
        rec_t e;
        fill_noop();
        Reset = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        o = observed();
        e = '0;
        e.nx = 4'd1;
        n_checks++;
        if (o !== e) begin
            n_fails++;
            $display("FAIL reset_hold: got %h want %h", o, e);
        end
        run_trace("reset_release", 3);
    endtask

    task automatic test_program();
        fill_noop();
        rom[0] = 16'h21B2;
        rom[1] = 16'h21C3;
        rom[2] = 16'h3234;
        rom[3] = 16'h1480;
        rom[4] = 16'h5000;
        run_trace("program", 38);
    endtask

    task automatic test_sub();
        fill_noop();
        rom[0] = 16'h4567;
        rom[1] = 16'h5000;
        run_trace("sub", 10);
    endtask

    task automatic test_noop_opcodes();
        fill_noop();
        rom[0] = 16'h0000;
        rom[1] = 16'hF123;
        for (int i = 2; i < 10; i++) rom[i] = {4'(6 + i - 2), 12'($urandom)};
        rom[10] = 16'h5ABC;
        run_trace("noop_ops", 40);
    endtask

    task automatic test_pc_wrap();
        fill_noop();
        run_trace("pc_wrap", 3 * 130 + 4);
    endtask

    task automatic test_random();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 128; i++) begin
                rom[i] = 16'($urandom);
                if (rom[i][15:12] == 4'd5 && ($urandom % 8) != 0) rom[i][15:12] = 4'd3;
            end
            run_trace("random", 300);
        end
    endtask

    task automatic test_reset_mid_store();
        int guard;
        fill_noop();
        rom[0] = 16'h1480;
        rom[1] = 16'h5000;
        Reset = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        guard = 0;
        while (State !== 4'd6 && guard < 10) begin
            @(negedge Clk);
            guard++;
        end
        n_checks++;
        if (State !== 4'd6) begin
            n_fails++;
            $display("FAIL mid_store_reach: state %0d want 6", State);
        end
        // Mid-cycle: assert reset between edges and look before the next edge
        Reset = 1'b0;
        #1;
        n_checks++;
        if (D_Wr !== 1'b0 || State !== 4'd0 || PC_Out !== 7'd0 || IR_Out !== 16'd0) begin
            n_fails++;
            $display("FAIL mid_store_reset: D_Wr %b st %0d pc %h ir %h want 0 0 00 0000",
                     D_Wr, State, PC_Out, IR_Out);
        end
        @(negedge Clk);
        run_trace("after_mid_reset", 12);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        Reset    = 1'b0;
        test_reset();
        test_program();
        test_sub();
        test_noop_opcodes();
        test_pc_wrap();
        test_random();
        test_reset_mid_store();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
